// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave timer sequencing controller.
package microondas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  function automatic logic is_bcd(input logic [3:0] v);
    return v <= BCD_NINE;
  endfunction

endpackage

// File: rtl/microondas_controle_if.sv
// Keypad/button/tick inputs and display/relay outputs of the cook-time controller.
interface microondas_controle_if;
  logic [3:0] d;
  logic       load_n;
  logic       tick_1hz;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       mag_on;
  logic       beep;
  logic       busy;

  modport master (
    output d, load_n, tick_1hz, start, stop_clear, door_closed,
    input  min_tens, min_ones, sec_tens, sec_ones, mag_on, beep, busy
  );

  modport slave (
    input  d, load_n, tick_1hz, start, stop_clear, door_closed,
    output min_tens, min_ones, sec_tens, sec_ones, mag_on, beep, busy
  );
endinterface

// File: rtl/bcd_mmss_down.sv
// Combinational one-second BCD decrement of an mm:ss value; zero flags a 00:00 input.
module bcd_mmss_down
  import microondas_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  zero
);

  always_comb begin
    nxt = cur;
    if (cur.sec_ones == 4'd0) begin
      nxt.sec_ones = BCD_NINE;
      if (cur.sec_tens == 4'd0) begin
        nxt.sec_tens = BCD_FIVE;
        if (cur.min_ones == 4'd0) begin
          nxt.min_ones = BCD_NINE;
          nxt.min_tens = cur.min_tens - 4'd1;
        end else begin
          nxt.min_ones = cur.min_ones - 4'd1;
        end
      end else begin
        nxt.sec_tens = cur.sec_tens - 4'd1;
      end
    end else begin
      nxt.sec_ones = cur.sec_ones - 4'd1;
    end
  end

  assign zero = (cur == '0);

endmodule

// File: rtl/microondas_controle.sv
// Microwave cook-time sequencer: digit entry, countdown, door/stop gating, end beep.
module microondas_controle
  import microondas_pkg::*;
#(
  parameter int BEEP_S = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  microondas_controle_if.slave bus
);

  state_t     state_q, state_d;
  mmss_t      time_q, time_d, time_dec;
  logic [3:0] beep_cnt_q, beep_cnt_d;
  logic       beep_q, beep_d;
  logic       mag_on_q, busy_q;
  logic       load_n_q, start_q, stop_q;
  logic       time_zero;
  logic       digit_ev, start_ev, stop_ev;

  bcd_mmss_down u_dec (
    .cur  (time_q),
    .nxt  (time_dec),
    .zero (time_zero)
  );

  assign digit_ev = load_n_q & ~bus.load_n;
  assign start_ev = bus.start & ~start_q;
  assign stop_ev  = bus.stop_clear & ~stop_q;

  always_comb begin
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    time_d     = time_q;
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (stop_ev) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start_ev && state_q == ENTRY && bus.door_closed && !time_zero) begin
          state_d = COOK;
        end else if (digit_ev && is_bcd(bus.d)) begin
          state_d = ENTRY;
          time_d  = {time_q.min_ones, time_q.sec_tens, time_q.sec_ones, bus.d};
        end
      end
      COOK: begin
        if (stop_ev || !bus.door_closed) begin
          state_d = PAUSE;
        end else if (bus.tick_1hz) begin
          time_d = time_dec;
          if (time_q == 16'h0001) begin
            state_d    = DONE;
            beep_d     = 1'b1;
            beep_cnt_d = 4'(BEEP_S);
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start_ev && bus.door_closed && !time_zero) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop_ev) begin
          state_d    = IDLE;
          time_d     = '0;
          beep_d     = 1'b0;
          beep_cnt_d = 4'd0;
        end else if (bus.tick_1hz) begin
          beep_cnt_d = beep_cnt_q - 4'd1;
          if (beep_cnt_q == 4'd1) begin
            state_d = IDLE;
            beep_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Relay and busy are registered from the next state so they track the state edge exactly.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      time_q     <= '0;
      beep_q     <= 1'b0;
      beep_cnt_q <= 4'd0;
      mag_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      load_n_q   <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
      mag_on_q   <= (state_d == COOK);
      busy_q     <= (state_d == COOK) || (state_d == PAUSE);
      load_n_q   <= bus.load_n;
      start_q    <= bus.start;
      stop_q     <= bus.stop_clear;
    end
  end

  assign bus.min_tens = time_q.min_tens;
  assign bus.min_ones = time_q.min_ones;
  assign bus.sec_tens = time_q.sec_tens;
  assign bus.sec_ones = time_q.sec_ones;
  assign bus.mag_on   = mag_on_q;
  assign bus.beep     = beep_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_microondas_controle.sv
// Scoreboard bench for microondas_controle: expected display/relay snapshots are queued per stimulus.
module tb_microondas_controle;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  microondas_controle_if bus ();

  microondas_controle #(.BEEP_S(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [18:0] val;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got mmss=%h mag=%b beep=%b busy=%b, expected mmss=%h mag=%b beep=%b busy=%b",
               tag, act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [18:0] observe();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.mag_on, bus.beep, bus.busy};
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] t, input logic m, input logic b, input logic bu);
    sb_t e;
    e.tag = tag;
    e.val = {t, m, b, bu};
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(), e.val);
    end
  endtask

  // Queue the expectation, let one edge happen, then compare.
  task automatic expect_after(input string tag, input logic [15:0] t, input logic m, input logic b, input logic bu);
    sb_push(tag, t, m, b, bu);
    cyc(1);
    sb_drain();
  endtask

  task automatic press(input string tag, input logic [3:0] k,
                       input logic [15:0] t, input logic m, input logic b, input logic bu);
    bus.d      = k;
    bus.load_n = 1'b0;
    expect_after(tag, t, m, b, bu);
    cyc(9);
    bus.load_n = 1'b1;
    cyc(10);
  endtask

  task automatic pulse_start(input string tag, input logic [15:0] t, input logic m, input logic b, input logic bu);
    bus.start = 1'b1;
    expect_after(tag, t, m, b, bu);
    cyc(2);
    bus.start = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_stop(input string tag, input logic [15:0] t, input logic m, input logic b, input logic bu);
    bus.stop_clear = 1'b1;
    expect_after(tag, t, m, b, bu);
    cyc(2);
    bus.stop_clear = 1'b0;
    cyc(2);
  endtask

  task automatic tick(input string tag, input logic [15:0] t, input logic m, input logic b, input logic bu);
    bus.tick_1hz = 1'b1;
    expect_after(tag, t, m, b, bu);
    bus.tick_1hz = 1'b0;
    cyc(3);
  endtask

  initial begin
    bus.d           = 4'd0;
    bus.load_n      = 1'b1;
    bus.tick_1hz    = 1'b0;
    bus.start       = 1'b0;
    bus.stop_clear  = 1'b0;
    bus.door_closed = 1'b1;

    cyc(2);
    expect_after("reset_state", 16'h0000, 0, 0, 0);
    reset = 1'b0;
    cyc(2);

    // Entry and invalid digit
    press("key1", 4'd1, 16'h0001, 0, 0, 0);
    press("key3", 4'd3, 16'h0013, 0, 0, 0);
    press("key0", 4'd0, 16'h0130, 0, 0, 0);
    press("key_hexC", 4'hC, 16'h0130, 0, 0, 0);
    pulse_stop("clear_entry", 16'h0000, 0, 0, 0);

    // 00:00 start refused, then a 3 s cook to DONE and beep
    press("key0_first", 4'd0, 16'h0000, 0, 0, 0);
    pulse_start("start_zero", 16'h0000, 0, 0, 0);
    press("key3b", 4'd3, 16'h0003, 0, 0, 0);
    pulse_start("start_3s", 16'h0003, 1, 0, 1);
    tick("tick_0002", 16'h0002, 1, 0, 1);
    tick("tick_0001", 16'h0001, 1, 0, 1);
    tick("tick_done", 16'h0000, 0, 1, 0);
    press("key_in_done", 4'd7, 16'h0000, 0, 1, 0);
    tick("beep_1", 16'h0000, 0, 1, 0);
    tick("beep_2", 16'h0000, 0, 1, 0);
    tick("beep_off", 16'h0000, 0, 0, 0);
    press("key_after_done", 4'd5, 16'h0005, 0, 0, 0);
    pulse_stop("clear_5", 16'h0000, 0, 0, 0);

    // Minute borrow 01:00 -> 00:59
    press("k1_100", 4'd1, 16'h0001, 0, 0, 0);
    press("k0_100", 4'd0, 16'h0010, 0, 0, 0);
    press("k0b_100", 4'd0, 16'h0100, 0, 0, 0);
    pulse_start("start_100", 16'h0100, 1, 0, 1);
    tick("tick_0059", 16'h0059, 1, 0, 1);
    pulse_stop("stop_pause_59", 16'h0059, 0, 0, 1);
    pulse_stop("stop_idle_59", 16'h0000, 0, 0, 0);

    // Tens-of-minutes borrow 10:00 -> 09:59
    for (int i = 0; i < 4; i++) begin
      logic [3:0] k;
      logic [15:0] t;
      k = (i == 0) ? 4'd1 : 4'd0;
      t = 16'h1000 >> (4 * (3 - i));
      press("k_1000", k, t, 0, 0, 0);
    end
    pulse_start("start_1000", 16'h1000, 1, 0, 1);
    tick("tick_0959", 16'h0959, 1, 0, 1);
    pulse_stop("stop_pause_959", 16'h0959, 0, 0, 1);
    pulse_stop("stop_idle_959", 16'h0000, 0, 0, 0);

    // Fifth digit drops the oldest
    press("k5_1", 4'd1, 16'h0001, 0, 0, 0);
    press("k5_2", 4'd2, 16'h0012, 0, 0, 0);
    press("k5_3", 4'd3, 16'h0123, 0, 0, 0);
    press("k5_4", 4'd4, 16'h1234, 0, 0, 0);
    press("k5_5", 4'd5, 16'h2345, 0, 0, 0);
    pulse_stop("clear_2345", 16'h0000, 0, 0, 0);

    // Out-of-range seconds count literally
    press("k90_9", 4'd9, 16'h0009, 0, 0, 0);
    press("k90_0", 4'd0, 16'h0090, 0, 0, 0);
    pulse_start("start_90", 16'h0090, 1, 0, 1);
    tick("tick_0089", 16'h0089, 1, 0, 1);
    pulse_stop("stop_pause_89", 16'h0089, 0, 0, 1);
    pulse_stop("stop_idle_89", 16'h0000, 0, 0, 0);

    // Door open mid-cook at 00:45
    press("k45_4", 4'd4, 16'h0004, 0, 0, 0);
    press("k45_5", 4'd5, 16'h0045, 0, 0, 0);
    pulse_start("start_45", 16'h0045, 1, 0, 1);
    bus.door_closed = 1'b0;
    expect_after("door_open", 16'h0045, 0, 0, 1);
    cyc(2);
    tick("frozen_tick1", 16'h0045, 0, 0, 1);
    tick("frozen_tick2", 16'h0045, 0, 0, 1);
    pulse_start("start_door_open", 16'h0045, 0, 0, 1);
    bus.door_closed = 1'b1;
    expect_after("door_closed", 16'h0045, 0, 0, 1);
    cyc(2);
    pulse_start("resume_45", 16'h0045, 1, 0, 1);
    tick("tick_0044", 16'h0044, 1, 0, 1);
    pulse_stop("stop_pause_44", 16'h0044, 0, 0, 1);
    pulse_stop("stop_idle_44", 16'h0000, 0, 0, 0);

    // Tick and stop together at 00:10
    press("k10_1", 4'd1, 16'h0001, 0, 0, 0);
    press("k10_0", 4'd0, 16'h0010, 0, 0, 0);
    pulse_start("start_10", 16'h0010, 1, 0, 1);
    bus.tick_1hz   = 1'b1;
    bus.stop_clear = 1'b1;
    expect_after("tick_and_stop", 16'h0010, 0, 0, 1);
    bus.tick_1hz   = 1'b0;
    cyc(2);
    bus.stop_clear = 1'b0;
    cyc(2);
    pulse_stop("second_stop", 16'h0000, 0, 0, 0);

    // Reset mid-cook at 00:20 with start held across release
    press("k20_2", 4'd2, 16'h0002, 0, 0, 0);
    press("k20_0", 4'd0, 16'h0020, 0, 0, 0);
    pulse_start("start_20", 16'h0020, 1, 0, 1);
    reset     = 1'b1;
    bus.start = 1'b1;
    expect_after("reset_mid_cook", 16'h0000, 0, 0, 0);
    reset = 1'b0;
    cyc(2);
    press("key_start_held", 4'd7, 16'h0007, 0, 0, 0);
    sb_push("no_start_event", 16'h0007, 0, 0, 0);
    cyc(3);
    sb_drain();
    bus.start = 1'b0;
    cyc(2);
    pulse_start("start_after_release", 16'h0007, 1, 0, 1);
    pulse_stop("final_pause", 16'h0007, 0, 0, 1);
    pulse_stop("final_idle", 16'h0000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/microondas_controle.md
Name: microondas_controle

Overview:
- Sequencing controller for the keypad/timer entry datapath of the microwave timer.
- Consumes the entry block's BCD digit strobe (d, load_n) and its 1 Hz pulse, and assembles a 4-digit mm:ss cook time.
- Runs the countdown, gates the magnetron on the door and start/stop commands, and signals end of cooking with a timed beep.
- Sits between the keypad entry block and the display/relay drivers.

Parameters:
- BEEP_S, 3, number of tick_1hz pulses the beep output stays high in DONE (1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  4  BCD digit from the entry block; valid while load_n=0.
- load_n  in  1  active-low digit strobe, level; one key press = one low interval.
- tick_1hz  in  1  single-cycle 1 Hz pulse from the entry block.
- start  in  1  start/resume button, level, active-high.
- stop_clear  in  1  stop/clear button, level, active-high.
- door_closed  in  1  1 = door closed.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
- mag_on  out  1  magnetron relay enable.
- beep  out  1  end-of-cook buzzer.
- busy  out  1  high in COOK or PAUSE.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-cook):
  - state=IDLE; all digits=0; mag_on=0, beep=0, busy=0.
  - Edge registers: load_n_q=1, start_q=0, stop_q=0.
  - Beep counter=0.
- Edge detection:
  - Digit event: load_n_q=1 and load_n=0 at the same edge.
  - Start event: start=1 and start_q=0.
  - Stop event: stop_clear=1 and stop_q=0.
  - Holding a button or key produces exactly one event.
- States: IDLE, ENTRY, COOK, PAUSE, DONE.
- Digit entry, accepted only in IDLE and ENTRY:
  - Shift left, new digit into sec_ones: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=d.
  - d>9: event ignored, no shift.
  - IDLE -> ENTRY on the first accepted digit, even if d=0.
  - A fifth digit drops the old min_tens.
  - Digit events in COOK, PAUSE and DONE are ignored.
- Start event:
  - ENTRY or PAUSE -> COOK only if door_closed=1 and time != 00:00; otherwise ignored.
  - Ignored in IDLE, COOK and DONE.
- Stop event:
  - COOK -> PAUSE; digits held.
  - ENTRY, PAUSE or DONE -> IDLE; digits cleared to 0, beep=0.
- Door: door_closed=0 in COOK -> PAUSE at that edge.
- Priority within one edge, highest first: reset > stop > door open > tick > start > digit.
  - A tick coinciding with stop or door-open in COOK does not decrement.
- Countdown in COOK, on each tick_1hz, BCD decrement:
  - Seconds:
    - sec_ones 0 -> 9 with borrow, else -1.
    - On borrow: sec_tens 0 -> 5 with borrow to minutes, else -1.
  - Minutes:
    - min_ones 0 -> 9 with borrow, else -1.
    - On borrow: min_tens -1.
  - Entered seconds above 59 (e.g. 0:90) count down literally: 90, 89, ... 00.
  - If the pre-decrement value is 00:01, the result is 00:00 and state -> DONE at the same edge.
- mag_on: registered, equals (next state == COOK); high exactly while in COOK, so it drops on the same edge the state leaves COOK.
- busy: registered, equals (next state is COOK or PAUSE).
- DONE:
  - beep=1 on entry; beep counter loaded with BEEP_S.
  - Each tick_1hz decrements the counter.
  - When a tick arrives with the counter at 1: beep=0, state -> IDLE.
  - Digits remain 00:00.
- Latency:
  - Digit visible on outputs the cycle after the digit-event edge.
  - mag_on rises the cycle after the start-event edge.
- Invariants: no output depends combinationally on any input; mag_on=1 implies state=COOK and door_closed was 1 at the previous edge.

Decomposition:
- Package microondas_pkg:
  - State encoding constants: IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4, 3-bit.
  - BCD_NINE, BCD_FIVE constants.
- Sub-module bcd_mmss_down: 16-bit mm:ss combinational decrementer with a zero flag.
  - Instantiated once, so the borrow chain is verified standalone.

Test Plan:
- Keys 1, 3, 0 via load_n pulses of 10 cycles each, 10-cycle gaps -> display 01:30, state ENTRY, mag_on=0; d=4'hC pulse -> display unchanged.
- From 00:03 with door closed, start pulse -> mag_on=1 next cycle, busy=1; 3 ticks -> 00:02, 00:01, 00:00; DONE and mag_on=0 at the third tick edge; beep=1 for exactly 3 further ticks, then IDLE.
- From 01:00 in COOK, one tick -> 00:59; from 10:00, one tick -> 09:59.
- Mid-cook at 00:45:
  - Door open -> PAUSE, mag_on=0, display frozen through 2 ticks.
  - Start with door still open -> ignored.
  - Door close, then start -> COOK, resumes at 00:45.
- Simultaneous tick and stop in COOK at 00:10 -> PAUSE, display stays 00:10; second stop -> IDLE, 00:00.
- Reset asserted mid-COOK at 00:20 for one cycle -> next cycle IDLE, 00:00, mag_on=0, beep=0, busy=0; start held high across reset release -> no start event.
